// File: rtl/uart.sv
// 8-bit 8N1 UART transceiver; BAUD_DIV clk cycles per bit.
// tx_done pulses for one cycle at the end of the stop bit; rx_rdy is held until clr_rx_rdy.
module uart #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy
);

    logic [9:0]  tx_shift;
    logic [3:0]  tx_bits;
    logic [15:0] tx_baud;
    logic        tx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '1;
            tx_bits  <= '0;
            tx_baud  <= '0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (trmt) begin
                tx_shift <= {1'b1, tx_data, 1'b0};
                tx_bits  <= '0;
                tx_baud  <= '0;
                tx_busy  <= 1'b1;
            end else if (tx_busy) begin
                if (tx_baud == 16'(BAUD_DIV - 1)) begin
                    tx_baud  <= '0;
                    tx_shift <= {1'b1, tx_shift[9:1]};
                    if (tx_bits == 4'd9) begin
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end else begin
                        tx_bits <= tx_bits + 4'd1;
                    end
                end else begin
                    tx_baud <= tx_baud + 16'd1;
                end
            end
        end
    end

    assign TX = tx_shift[0];

    logic        rx_meta, rx_sync;
    logic [7:0]  rx_shift;
    logic [3:0]  rx_bits;
    logic [15:0] rx_baud;
    logic        rx_busy;

    // Samples land mid-bit: first count is half a bit, then full bits; start bit shifts out of the 8-bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_shift <= '0;
            rx_bits  <= '0;
            rx_baud  <= '0;
            rx_busy  <= 1'b0;
            rx_data  <= '0;
            rx_rdy   <= 1'b0;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            if (clr_rx_rdy)
                rx_rdy <= 1'b0;
            if (!rx_busy) begin
                if (!rx_sync) begin
                    rx_busy <= 1'b1;
                    rx_baud <= 16'(BAUD_DIV / 2);
                    rx_bits <= '0;
                    rx_rdy  <= 1'b0;
                end
            end else if (rx_baud == 16'd0) begin
                rx_baud <= 16'(BAUD_DIV - 1);
                rx_bits <= rx_bits + 4'd1;
                if (rx_bits == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_rdy  <= 1'b1;
                    rx_data <= rx_shift;
                end else begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                end
            end else begin
                rx_baud <= rx_baud - 16'd1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles two UART bytes (high first) into a 16-bit command; passes the response byte out.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_wrapper #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned BAUD_DIV       = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 32'h00FF_FFFF) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range");
    end

    typedef enum logic {IDLE, LOW} state_t;

    state_t     state, next_state;
    logic [7:0] rx_data;
    logic [7:0] high_byte;
    logic       rx_rdy, clr_rx_rdy;
    logic       cap_high, cap_low;

    uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .tx_data    (resp),
        .trmt       (trmt),
        .tx_done    (tx_done),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy)
    );

`ifdef CMD_TIMEOUT_EN
    logic [23:0] to_cnt;
    logic        timeout_hit, drop_high;

    assign timeout_hit = (state == LOW) && (to_cnt == 24'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (cap_high)
            to_cnt <= '0;
        else if (state == LOW && !rx_rdy)
            to_cnt <= to_cnt + 24'd1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        clr_rx_rdy = 1'b0;
        cap_high   = 1'b0;
        cap_low    = 1'b0;
`ifdef CMD_TIMEOUT_EN
        drop_high  = 1'b0;
`endif
        case (state)
            IDLE: if (rx_rdy) begin
                clr_rx_rdy = 1'b1;
                cap_high   = 1'b1;
                next_state = LOW;
            end
            LOW: if (rx_rdy) begin
                clr_rx_rdy = 1'b1;
                cap_low    = 1'b1;
                next_state = IDLE;
            end
`ifdef CMD_TIMEOUT_EN
            // A byte arriving on the timeout cycle still wins.
            else if (timeout_hit) begin
                drop_high  = 1'b1;
                next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_byte <= '0;
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
        end else begin
            if (cap_high)
                high_byte <= rx_data;
`ifdef CMD_TIMEOUT_EN
            else if (drop_high)
                high_byte <= '0;
`endif
            if (cap_low)
                cmd <= {high_byte, rx_data};
            if (cap_low)
                cmd_rdy <= 1'b1;
            else if (cap_high || clr_cmd_rdy)
                cmd_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: serial byte driver, TX frame decoder and a byte-pairing reference model.
module tb_uart_cmd_wrapper;

    localparam int unsigned BAUD      = 16;
    localparam int unsigned TO_CYCLES = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = '0;
    logic        trmt = 1'b0;
    logic        tx_done;

    int checks = 0;
    int errors = 0;
    int bytes_sent = 0;
    int clr_rx_seen = 0;
    bit mon_en = 1'b0;

    // Reference model: bytes pair up high-then-low.
    logic [15:0] m_cmd = '0;
    logic        m_rdy = 1'b0;
    logic        m_pend = 1'b0;
    logic [7:0]  m_high = '0;

    uart_cmd_wrapper #(.TIMEOUT_CYCLES(TO_CYCLES), .BAUD_DIV(BAUD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_pend) begin
            m_pend = 1'b1;
            m_high = b;
            m_rdy  = 1'b0;
        end else begin
            m_cmd  = {m_high, b};
            m_rdy  = 1'b1;
            m_pend = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_cmd  = '0;
        m_rdy  = 1'b0;
        m_pend = 1'b0;
        m_high = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = frame[i];
            repeat (BAUD) @(negedge clk);
        end
        bytes_sent++;
    endtask

    task automatic send_cmd_byte(input logic [7:0] b);
        send_byte(b);
        model_byte(b);
        @(negedge clk);
        check("cmd", {16'h0, cmd}, {16'h0, m_cmd});
        check("cmd_rdy", {31'h0, cmd_rdy}, {31'h0, m_rdy});
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
        check("clr_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
        check("cmd_after_clr", {16'h0, cmd}, {16'h0, m_cmd});
    endtask

    task automatic capture_tx(output logic [7:0] b, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        b  = '0;
        while (TX !== 1'b0 && n < 4 * BAUD) begin
            @(negedge clk);
            n++;
        end
        if (TX !== 1'b0) return;
        repeat (BAUD / 2) @(negedge clk);
        if (TX !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge clk);
            b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        ok = (TX === 1'b1);
    endtask

    // cmd_rdy must rise exactly one clk after rx_rdy, and cmd may only change as it rises.
    logic        prev_rx_rdy = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [15:0] prev_cmd = '0;
    always @(negedge clk) begin
        if (dut.clr_rx_rdy === 1'b1)
            clr_rx_seen++;
        if (mon_en && rst_n) begin
            if (cmd_rdy && !prev_rdy)
                check("rdy_latency", {31'h0, prev_rx_rdy}, 32'h1);
            if (cmd !== prev_cmd)
                check("cmd_change_with_rdy", {31'h0, (cmd_rdy && !prev_rdy)}, 32'h1);
        end
        prev_rx_rdy = dut.rx_rdy;
        prev_rdy    = cmd_rdy;
        prev_cmd    = cmd;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [7:0] tx_byte;
    bit         tx_ok;
    int         wait_n;
    int         gap;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cmd", {16'h0, cmd}, 32'h0);
        check("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
        check("rst_tx_idle", {31'h0, TX}, 32'h1);
        check("rst_tx_done", {31'h0, tx_done}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        send_cmd_byte(8'hA5);
        send_cmd_byte(8'h3C);
        check("cmd_A53C", {16'h0, cmd}, 32'hA53C);

        pulse_clr();
        send_cmd_byte(8'h12);
        send_cmd_byte(8'h34);

        send_cmd_byte(8'hFF);
        send_cmd_byte(8'h00);
        send_cmd_byte(8'hFF);
        fork
            send_cmd_byte(8'h00);
            begin
                wait_n = 0;
                while (dut.rx_rdy !== 1'b1 && wait_n < 20 * BAUD) begin
                    @(negedge clk);
                    wait_n++;
                end
                check("wait_low_rx_rdy", {31'h0, (wait_n < 20 * BAUD)}, 32'h1);
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
            end
        join

        fork
            begin
                send_cmd_byte(8'h9A);
                send_cmd_byte(8'hBC);
            end
            begin
                @(negedge clk);
                resp = 8'hA5;
                trmt = 1'b1;
                @(negedge clk);
                trmt = 1'b0;
                capture_tx(tx_byte, tx_ok);
                check("tx_frame", {31'h0, tx_ok}, 32'h1);
                check("tx_byte", {24'h0, tx_byte}, 32'hA5);
                wait_n = 0;
                while (tx_done !== 1'b1 && wait_n < 2 * BAUD) begin
                    @(negedge clk);
                    wait_n++;
                end
                check("tx_done", {31'h0, tx_done}, 32'h1);
            end
        join
        repeat (2 * BAUD) @(negedge clk);

        send_cmd_byte(8'h11);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_cmd", {16'h0, cmd}, 32'h0);
            check("midrst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
            check("midrst_tx", {31'h0, TX}, 32'h1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        send_cmd_byte(8'h56);
        send_cmd_byte(8'h78);

        send_cmd_byte(8'hAA);
        repeat (TO_CYCLES + 200) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
        m_pend = 1'b0;
`endif
        send_cmd_byte(8'hBB);
        send_cmd_byte(8'hCC);
`ifdef CMD_TIMEOUT_EN
        check("timeout_cmd", {16'h0, cmd}, 32'hBBCC);
`else
        check("no_timeout_cmd", {16'h0, cmd}, 32'hAABB);
`endif

        for (int k = 0; k < 24; k++) begin
            gap = $urandom_range(0, 30);
            repeat (gap) @(negedge clk);
            if ($urandom_range(0, 3) == 0)
                pulse_clr();
            send_cmd_byte(8'($urandom));
        end

        repeat (4) @(negedge clk);
        check("clr_rx_rdy_per_byte", clr_rx_seen, bytes_sent);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
